// File: rtl/mem_res_model.sv
// mem_res_model: stateful data-memory responder for a split read/write
// request/response port pair. Requests are queued per channel and answered
// in order once they are LATENCY cycles old and stall_i is low.
//
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   rd_req_addr_i/valid_i    read request (byte address)
//   rd_res_data/valid/error  read response (data/error are 0 when not valid)
//   wr_req_addr/data/mask/valid_i  write request, mask bit n enables byte n
//   wr_res_valid/error_o     write response
//   stall_i                  blocks responses on both channels
//   overflow_o               sticky: a request was dropped on a full queue
//   rd/wr_pending_o          queue occupancy, 0..QUEUE_DEPTH

// In-order request queue. Each slot carries an age that saturates at LAT;
// the head is ready once it has aged LAT-1 cycles past its push edge.
module mem_res_queue #(
  parameter int W   = 8,
  parameter int QD  = 4,
  parameter int LAT = 1
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_push,
  input  logic [W-1:0]          i_data,
  input  logic                  i_pop,
  output logic [W-1:0]          o_head,
  output logic                  o_ready,
  output logic [$clog2(QD):0]   o_count,
  output logic                  o_drop
);
  localparam int AW = $clog2(QD);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QD);
  localparam logic [3:0]  ELIG_AGE = 4'(LAT - 1);
  localparam logic [3:0]  MAX_AGE  = 4'(LAT);

  logic [W-1:0]  r_data [QD];
  logic [3:0]    r_age  [QD];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_push;

  // A full queue still accepts when the head leaves on the same edge.
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_push  = i_push && (!w_full || i_pop);
  assign o_drop  = i_push && !w_push;
  assign o_head  = r_data[r_rp];
  assign o_ready = (r_cnt != '0) && (r_age[r_rp] >= ELIG_AGE);
  assign o_count = r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !i_pop)      r_cnt <= r_cnt + 1'b1;
      else if (i_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Payload and age need no reset: a slot is only read after its push.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < QD; i++) begin
      if (w_push && r_wp == AW'(i)) begin
        r_data[i] <= i_data;
        r_age[i]  <= '0;
      end else if (r_age[i] < MAX_AGE) begin
        r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end
endmodule

module mem_res_model #(
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1,
  parameter int          QUEUE_DEPTH = 4
)(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [31:0]                    rd_req_addr_i,
  input  logic                           rd_req_valid_i,
  output logic [31:0]                    rd_res_data_o,
  output logic                           rd_res_valid_o,
  output logic                           rd_res_error_o,
  input  logic [31:0]                    wr_req_addr_i,
  input  logic [31:0]                    wr_req_data_i,
  input  logic [3:0]                     wr_req_mask_i,
  input  logic                           wr_req_valid_i,
  output logic                           wr_res_valid_o,
  output logic                           wr_res_error_o,
  input  logic                           stall_i,
  output logic                           overflow_o,
  output logic [$clog2(QUEUE_DEPTH):0]   rd_pending_o,
  output logic [$clog2(QUEUE_DEPTH):0]   wr_pending_o
);
  localparam int DW = DEPTH_LOG2;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'd4 << DW);

  typedef struct packed {
    logic          err;
    logic [DW-1:0] idx;
  } rd_ent_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] idx;
    logic [31:0]   data;
    logic [3:0]    mask;
  } wr_ent_t;

  // Error and index are resolved at request time so responses depend on
  // registered state only.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, a} >= END_ADDR);
  endfunction

  function automatic logic [DW-1:0] addr_idx(input logic [31:0] a);
    return DW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] r_mem [2**DW];
  logic        r_overflow;
  rd_ent_t     w_rd_in, w_rd_head;
  wr_ent_t     w_wr_in, w_wr_head;
  logic        w_rd_ready, w_wr_ready, w_rd_fire, w_wr_fire;
  logic        w_rd_drop, w_wr_drop;

  assign w_rd_in = '{err: addr_bad(rd_req_addr_i), idx: addr_idx(rd_req_addr_i)};
  assign w_wr_in = '{err: addr_bad(wr_req_addr_i), idx: addr_idx(wr_req_addr_i),
                     data: wr_req_data_i, mask: wr_req_mask_i};

  mem_res_queue #(.W($bits(rd_ent_t)), .QD(QUEUE_DEPTH), .LAT(LATENCY)) u_rdq (
    .clk_i(clk_i), .rst_i(rst_i), .i_push(rd_req_valid_i), .i_data(w_rd_in),
    .i_pop(w_rd_fire), .o_head(w_rd_head), .o_ready(w_rd_ready),
    .o_count(rd_pending_o), .o_drop(w_rd_drop));

  mem_res_queue #(.W($bits(wr_ent_t)), .QD(QUEUE_DEPTH), .LAT(LATENCY)) u_wrq (
    .clk_i(clk_i), .rst_i(rst_i), .i_push(wr_req_valid_i), .i_data(w_wr_in),
    .i_pop(w_wr_fire), .o_head(w_wr_head), .o_ready(w_wr_ready),
    .o_count(wr_pending_o), .o_drop(w_wr_drop));

  assign w_rd_fire = w_rd_ready && !stall_i;
  assign w_wr_fire = w_wr_ready && !stall_i;

  // Memory is read combinationally in the response cycle, so a same-cycle
  // write to the same word is seen only by later reads.
  assign rd_res_valid_o = w_rd_fire;
  assign rd_res_error_o = w_rd_fire && w_rd_head.err;
  assign rd_res_data_o  = (w_rd_fire && !w_rd_head.err) ? r_mem[w_rd_head.idx] : 32'h0;
  assign wr_res_valid_o = w_wr_fire;
  assign wr_res_error_o = w_wr_fire && w_wr_head.err;
  assign overflow_o     = r_overflow;

  always_ff @(posedge clk_i) begin
    if (w_wr_fire && !w_wr_head.err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_head.mask[b]) r_mem[w_wr_head.idx][8*b +: 8] <= w_wr_head.data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_overflow <= 1'b0;
    else if (w_rd_drop || w_wr_drop) r_overflow <= 1'b1;
  end
endmodule
